prga_fifo_multimode: RTL and testbench



---
 rtl/prga_fifo_pkg.sv | 12 +
 rtl/prga_fifo_lookahead_stage.sv | 46 ++++
 rtl/prga_fifo_multimode.sv | 135 +++++++++++++
 tb/tb_prga_fifo_multimode.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prga_fifo_pkg.sv
// Shared constants and helpers for the PRGA multimode FIFO.
package prga_fifo_pkg;

    localparam int PRGA_FIFO_MODE_NONLOOKAHEAD = 0;
    localparam int PRGA_FIFO_MODE_LOOKAHEAD    = 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int prga_fifo_ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/prga_fifo_lookahead_stage.sv
// One-entry prefetch register that turns the registered-read FIFO core
// into a first-word-fall-through interface.
module prga_fifo_lookahead_stage #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_empty_i,
    input  logic [DATA_WIDTH-1:0] core_rdata_i,
    output logic                  core_rd_o,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  empty_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        valid_d   = valid_q;
        data_d    = data_q;
        core_rd_o = !core_empty_i && (!valid_q || pop_i);
        if (core_rd_o) begin
            valid_d = 1'b1;
            data_d  = core_rdata_i;
        end else if (pop_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign dout_o  = data_q;
    assign empty_o = !valid_q;

endmodule

// File: rtl/prga_fifo_multimode.sv
// Single-clock FIFO with lookahead or registered-read output, occupancy count and almost-full.
// Optional sticky overflow/underflow outputs are enabled by defining PRGA_FIFO_ERROR_FLAGS_EN.
module prga_fifo_multimode
    import prga_fifo_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int DEPTH_LOG2            = 4,
    parameter int LOOKAHEAD             = PRGA_FIFO_MODE_NONLOOKAHEAD,
    parameter int ALMOST_FULL_THRESHOLD = 2**DEPTH_LOG2 - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int              PW           = prga_fifo_ptr_width(DEPTH_LOG2);
    localparam logic [PW-1:0]   CAPACITY     = PW'(2**DEPTH_LOG2);
    localparam logic [PW-1:0]   AF_THRESHOLD = PW'(ALMOST_FULL_THRESHOLD);

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q, count_d;
    logic                  full_q, almost_full_q;
    logic                  wr_acc, rd_acc, core_rd;
    logic [DATA_WIDTH-1:0] core_rdata;

    assign wr_acc     = wr && !full_q;
    assign rd_acc     = rd && !empty;
    assign core_rdata = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

    // count tracks words owned by the consumer side, including a prefetched head word.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_acc);
        rd_ptr_d = rd_ptr_q + PW'(core_rd);
        count_d  = count_q;
        if (wr_acc && !rd_acc) begin
            count_d = count_q + PW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            almost_full_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            full_q        <= (count_d == CAPACITY);
            almost_full_q <= (count_d >= AF_THRESHOLD);
        end
    end

    // NOTE: storage has no reset; only pointers and flags define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= din;
        end
    end

    if (LOOKAHEAD == PRGA_FIFO_MODE_LOOKAHEAD) begin : g_lookahead
        prga_fifo_lookahead_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_stage (
            .clk          (clk),
            .rst          (rst),
            .core_empty_i (wr_ptr_q == rd_ptr_q),
            .core_rdata_i (core_rdata),
            .core_rd_o    (core_rd),
            .pop_i        (rd),
            .dout_o       (dout),
            .empty_o      (empty)
        );
    end else begin : g_registered
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  empty_q;

        assign core_rd = rd && !empty_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q  <= '0;
                empty_q <= 1'b1;
            end else begin
                if (core_rd) begin
                    dout_q <= core_rdata;
                end
                empty_q <= (count_d == '0);
            end
        end

        assign dout  = dout_q;
        assign empty = empty_q;
    end

    assign full        = full_q;
    assign almost_full = almost_full_q;
    assign count       = count_q;

`ifdef PRGA_FIFO_ERROR_FLAGS_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_q  | (wr && full_q);
            underflow_q <= underflow_q | (rd && empty);
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_prga_fifo_multimode.sv
// Scoreboard bench for prga_fifo_multimode: one registered-read and one lookahead instance side by side.
module tb_prga_fifo_multimode;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr0, rd0, wr1, rd1;
    logic [31:0] din0, din1, dout0, dout1;
    logic        full0, full1, af0, af1, empty0, empty1;
    logic [3:0]  cnt0, cnt1;
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
    logic        ovf0, unf0, ovf1, unf1;
    bit          m_ovf0, m_unf0, m_ovf1, m_unf1;
`endif

    int          total = 0;
    int          bad   = 0;

    // Reference model state: word queues plus occupancy / prefetch tracking.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          m0_cnt;
    logic [31:0] m0_dout;
    int          m1_core;
    bit          m1_v;

    always #5 clk = ~clk;

    prga_fifo_multimode #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (3),
        .LOOKAHEAD  (0)
    ) u_nl (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr0),
        .din         (din0),
        .full        (full0),
        .almost_full (af0),
        .rd          (rd0),
        .dout        (dout0),
        .empty       (empty0),
        .count       (cnt0)
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
        ,
        .overflow    (ovf0),
        .underflow   (unf0)
`endif
    );

    prga_fifo_multimode #(
        .DATA_WIDTH (32),
        .DEPTH_LOG2 (3),
        .LOOKAHEAD  (1)
    ) u_la (
        .clk         (clk),
        .rst         (rst),
        .wr          (wr1),
        .din         (din1),
        .full        (full1),
        .almost_full (af1),
        .rd          (rd1),
        .dout        (dout1),
        .empty       (empty1),
        .count       (cnt1)
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
        ,
        .overflow    (ovf1),
        .underflow   (unf1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        m0_cnt  = 0;
        m0_dout = '0;
        m1_core = 0;
        m1_v    = 1'b0;
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
        m_ovf0 = 1'b0; m_unf0 = 1'b0; m_ovf1 = 1'b0; m_unf1 = 1'b0;
`endif
    endtask

    task automatic check_all();
        int m1_cnt;
        m1_cnt = m1_core + int'(m1_v);
        check("nl_count", 64'(cnt0),   64'(m0_cnt));
        check("nl_empty", 64'(empty0), 64'(m0_cnt == 0));
        check("nl_full",  64'(full0),  64'(m0_cnt == 8));
        check("nl_afull", 64'(af0),    64'(m0_cnt >= 6));
        check("nl_dout",  64'(dout0),  64'(m0_dout));
        check("la_count", 64'(cnt1),   64'(m1_cnt));
        check("la_empty", 64'(empty1), 64'(!m1_v));
        check("la_full",  64'(full1),  64'(m1_cnt == 8));
        check("la_afull", 64'(af1),    64'(m1_cnt >= 6));
        if (m1_v) check("la_dout", 64'(dout1), 64'(q1[0]));
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
        check("nl_ovf", 64'(ovf0), 64'(m_ovf0));
        check("nl_unf", 64'(unf0), 64'(m_unf0));
        check("la_ovf", 64'(ovf1), 64'(m_ovf1));
        check("la_unf", 64'(unf1), 64'(m_unf1));
`endif
    endtask

    // Drive one cycle on both instances, advance the model, then compare 1 time unit after the edge.
    task automatic step(input bit w0, input bit r0, input logic [31:0] d0,
                        input bit w1, input bit r1, input logic [31:0] d1);
        bit          wa0, ra0, wa1, pop1, fetch1;
        int          m1_cnt;
        logic [31:0] tmp;
        wr0 = w0; rd0 = r0; din0 = d0;
        wr1 = w1; rd1 = r1; din1 = d1;
        m1_cnt = m1_core + int'(m1_v);
        wa0    = w0 && (m0_cnt < 8);
        ra0    = r0 && (m0_cnt > 0);
        wa1    = w1 && (m1_cnt < 8);
        pop1   = r1 && m1_v;
        fetch1 = (m1_core > 0) && (!m1_v || pop1);
`ifdef PRGA_FIFO_ERROR_FLAGS_EN
        m_ovf0 |= w0 && (m0_cnt == 8);
        m_unf0 |= r0 && (m0_cnt == 0);
        m_ovf1 |= w1 && (m1_cnt == 8);
        m_unf1 |= r1 && !m1_v;
`endif
        @(posedge clk);
        #1;
        if (ra0) m0_dout = q0.pop_front();
        if (wa0) q0.push_back(d0);
        m0_cnt = m0_cnt + int'(wa0) - int'(ra0);
        if (pop1) tmp = q1.pop_front();
        if (wa1) q1.push_back(d1);
        m1_core = m1_core + int'(wa1) - int'(fetch1);
        m1_v    = fetch1 ? 1'b1 : (pop1 ? 1'b0 : m1_v);
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m0_cnt > 0 || m1_core > 0 || m1_v); i++) begin
            step(1'b0, m0_cnt > 0, '0, 1'b0, m1_v, '0);
        end
        check("drain_nl_empty", 64'(empty0), 64'(1));
        check("drain_la_empty", 64'(empty1), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] nl_words [4];
        nl_words = '{32'h5A, 32'hF6, 32'h09, 32'hC4};
        model_reset();
        rst = 1'b1;
        wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
        wr1 = 1'b0; rd1 = 1'b0; din1 = '0;
        #12;
        check_all();
        check("rst_nl_dout", 64'(dout0), 64'(0));
        check("rst_la_dout", 64'(dout1), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Registered-read sequence: four writes, then four reads.
        foreach (nl_words[i]) step(1'b1, 1'b0, nl_words[i], 1'b0, 1'b0, '0);
        foreach (nl_words[i]) step(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);

        // Fill both past capacity with no reads; extra words must be dropped.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h100 + i, 1'b1, 1'b0, 32'h200 + i);
        drain();

        // Lookahead: two-cycle write-to-visible, back-to-back pop, last-word pop with concurrent write.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'h81);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, 32'hE2);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h3C);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        drain();

        // Registered-read: rd on empty, then rd together with wr on empty.
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 32'h77, 1'b0, 1'b0, '0);
        check("nl_rdwr_empty_count", 64'(cnt0), 64'(1));
        drain();

        // Random traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end
        drain();

        // Asynchronous reset mid-stream with five words stored.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h300 + i, 1'b1, 1'b0, 32'h400 + i);
        check("pre_rst_nl_count", 64'(cnt0), 64'(5));
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        check("async_rst_nl_dout", 64'(dout0), 64'(0));
        check("async_rst_la_dout", 64'(dout1), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 32'hA0, 1'b1, 1'b0, 32'hA0);
        step(1'b0, 1'b1, '0, 1'b0, 1'b0, '0);
        check("post_rst_nl_first", 64'(dout0), 64'(32'hA0));
        check("post_rst_la_first", 64'(dout1), 64'(32'hA0));
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
